// File: rtl/instruction_fetch_unit.sv
// Fetch stage in front of a one-cycle-latency instruction ROM: owns the PC, issues reads,
// buffers returned words with their PC and hands them to decode over valid/ready.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 5,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        HSEL1,
    output logic        rd_en_rom,
    output logic [31:0] address_rom,
    input  logic [31:0] instruction,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [31:0]      PC_LIMIT  = RESET_PC + 32'(4 * ROM_WORDS);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]      buf_instr_q [DEPTH];
    logic [31:0]      buf_pc_q    [DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic             at_limit;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      redirect_aligned;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Decode handshake: a word transfers when if_valid & if_ready are both high at a rising
    // edge; if_instr/if_pc are held while if_valid & ~if_ready, and a redirect masks if_valid.
    assign if_valid = (count_q != '0) & ~redirect_valid;
    assign pop      = if_valid & if_ready;
    assign at_limit = (pc_q == PC_LIMIT);

    // Slots already promised (buffered plus the one in flight) must leave room for the new read.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = fetch_en & ~redirect_valid & ~at_limit & ~reset & (occupancy < DEPTH_OCC);
    assign push      = inflight_q & ~kill_q & ~redirect_valid;

    assign redirect_aligned = redirect_pc & ~32'h3;

    assign HSEL1       = issue;
    assign rd_en_rom   = issue;
    assign address_rom = pc_q;
    assign fetch_done  = at_limit;
    assign if_instr    = buf_instr_q[rd_ptr_q];
    assign if_pc       = buf_pc_q[rd_ptr_q];

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        kill_d        = 1'b0;
        count_d       = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_aligned;
            kill_d  = inflight_q;
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    buf_instr_q[wr_ptr_q] <= instruction;
                    buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
                    wr_ptr_q              <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: ROM slave model, queue-based reference model checked
// every cycle, plus directed scenarios for streaming, backpressure, redirect and reset.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_WORDS = 5;
  localparam int          DEPTH     = 3;
  localparam logic [31:0] LIMIT     = RESET_PC + 32'(4 * ROM_WORDS);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        HSEL1;
  logic        rd_en_rom;
  logic [31:0] address_rom;
  logic [31:0] instruction = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_done;

  int checks = 0;
  int failures = 0;

  logic [31:0] prog [5] = '{32'h002081b3, 32'h40218233, 32'h0020c2b3, 32'h0020e333, 32'h0020f3b3};

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .ROM_WORDS(ROM_WORDS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .HSEL1         (HSEL1),
    .rd_en_rom     (rd_en_rom),
    .address_rom   (address_rom),
    .instruction   (instruction),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .fetch_done    (fetch_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ROM slave ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    int idx;
    idx = int'((a - RESET_PC) >> 2);
    if (a >= RESET_PC && idx < ROM_WORDS) return prog[idx];
    return 32'hA500_0000 ^ a;
  endfunction

  always @(posedge clk) begin
    if (HSEL1 && rd_en_rom) instruction <= rom_word(address_rom);
  end

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_infl_pc = '0;
  int          m_infl = 0;
  bit          m_kill = 1'b0;
  bit          e_valid, e_pop, e_done, e_issue;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_pc = RESET_PC;
      m_infl = 0;
      m_infl_pc = '0;
      m_kill = 1'b0;
    end else begin
      e_valid = (exp_q.size() != 0) && !redirect_valid;
      e_pop   = e_valid && if_ready;
      e_done  = (m_pc == LIMIT);
      e_issue = fetch_en && !redirect_valid && !e_done &&
                (exp_q.size() + m_infl - (e_pop ? 1 : 0) < DEPTH);
      checks++;
      if (if_valid !== e_valid) begin
        failures++; $display("FAIL model_if_valid t=%0t got=%b exp=%b", $time, if_valid, e_valid);
      end
      checks++;
      if (rd_en_rom !== e_issue || HSEL1 !== e_issue) begin
        failures++; $display("FAIL model_issue t=%0t got=%b/%b exp=%b", $time, HSEL1, rd_en_rom, e_issue);
      end
      checks++;
      if (address_rom !== m_pc) begin
        failures++; $display("FAIL model_address t=%0t got=%h exp=%h", $time, address_rom, m_pc);
      end
      checks++;
      if (fetch_done !== e_done) begin
        failures++; $display("FAIL model_fetch_done t=%0t got=%b exp=%b", $time, fetch_done, e_done);
      end
      if (e_valid) begin
        checks++;
        if (if_instr !== exp_q[0][63:32] || if_pc !== exp_q[0][31:0]) begin
          failures++;
          $display("FAIL model_head t=%0t got=%h@%h exp=%h@%h", $time, if_instr, if_pc, exp_q[0][63:32], exp_q[0][31:0]);
        end
      end
      checks++;
      if (int'(dut.count_q) > DEPTH) begin
        failures++; $display("FAIL overflow t=%0t got=%0d exp<=%0d", $time, dut.count_q, DEPTH);
      end
      if (redirect_valid) begin
        exp_q.delete();
        m_pc = redirect_pc & ~32'h3;
        m_kill = (m_infl != 0);
        m_infl = 0;
      end else begin
        if (e_pop) void'(exp_q.pop_front());
        if (m_infl != 0 && !m_kill) exp_q.push_back({rom_word(m_infl_pc), m_infl_pc});
        m_kill = 1'b0;
        if (e_issue) begin
          m_infl = 1;
          m_infl_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end else begin
          m_infl = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_en = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0 || HSEL1 !== 1'b0 || rd_en_rom !== 1'b0 || fetch_done !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b%b%b%b exp=0000", if_valid, HSEL1, rd_en_rom, fetch_done);
    end
    checks++;
    if (if_instr !== 32'h0 || if_pc !== 32'h0) begin
      failures++; $display("FAIL reset_head got=%h@%h exp=0@0", if_instr, if_pc);
    end
    checks++;
    if (address_rom !== RESET_PC) begin
      failures++; $display("FAIL reset_address got=%h exp=%h", address_rom, RESET_PC);
    end
    repeat (2) next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || rd_en_rom !== 1'b0 || address_rom !== RESET_PC) begin
      failures++; $display("FAIL reset_release got=%b%b@%h exp=00@%h", if_valid, rd_en_rom, address_rom, RESET_PC);
    end
    next_cycle();
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (rd_en_rom !== (k < 5)) begin
        failures++; $display("FAIL stream_issue k=%0d got=%b exp=%b", k, rd_en_rom, k < 5);
      end
      checks++;
      if (if_valid !== (k >= 2 && k <= 6)) begin
        failures++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, if_valid, k >= 2 && k <= 6);
      end
      if (k >= 2 && k <= 6) begin
        checks++;
        if (if_instr !== prog[k-2] || if_pc !== 32'(4 * (k - 2))) begin
          failures++; $display("FAIL stream_word k=%0d got=%h@%h exp=%h@%h", k, if_instr, if_pc, prog[k-2], 4 * (k - 2));
        end
      end
      checks++;
      if (fetch_done !== (k >= 5)) begin
        failures++; $display("FAIL stream_done k=%0d got=%b exp=%b", k, fetch_done, k >= 5);
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (k >= 2) begin
        checks++;
        if (if_valid !== 1'b1 || if_instr !== prog[0] || if_pc !== RESET_PC) begin
          failures++; $display("FAIL bp_head k=%0d got=%b %h@%h exp=1 %h@%h", k, if_valid, if_instr, if_pc, prog[0], RESET_PC);
        end
        checks++;
        if (rd_en_rom !== (k < DEPTH)) begin
          failures++; $display("FAIL bp_issue k=%0d got=%b exp=%b", k, rd_en_rom, k < DEPTH);
        end
      end
      if (k == 6) begin
        checks++;
        if (int'(dut.count_q) !== DEPTH) begin
          failures++; $display("FAIL bp_count got=%0d exp=%0d", dut.count_q, DEPTH);
        end
      end
      next_cycle();
    end
    if_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (if_valid) begin
        checks++;
        if (got >= 5) begin
          failures++; $display("FAIL bp_extra got=%h@%h exp=none", if_instr, if_pc);
        end else if (if_instr !== prog[got] || if_pc !== 32'(4 * got)) begin
          failures++; $display("FAIL bp_order n=%0d got=%h@%h exp=%h@%h", got, if_instr, if_pc, prog[got], 4 * got);
        end
        got++;
      end
      next_cycle();
    end
    checks++;
    if (got !== 5) begin
      failures++; $display("FAIL bp_total got=%0d exp=5", got);
    end
  endtask

  task automatic test_redirect();
    int got;
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    repeat (2) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    #1;
    checks++;
    if (if_valid !== 1'b0 || rd_en_rom !== 1'b0) begin
      failures++; $display("FAIL redir_cycle got=%b%b exp=00", if_valid, rd_en_rom);
    end
    next_cycle();
    redirect_valid = 1'b0;
    got = 0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (if_valid) begin
        if (got == 0) begin
          checks++;
          if (c !== 3) begin
            failures++; $display("FAIL redir_latency got=%0d exp=3", c);
          end
        end
        checks++;
        if (got >= 3) begin
          failures++; $display("FAIL redir_extra got=%h@%h exp=none", if_instr, if_pc);
        end else if (if_instr !== prog[2+got] || if_pc !== 32'(8 + 4 * got)) begin
          failures++; $display("FAIL redir_word n=%0d got=%h@%h exp=%h@%h", got, if_instr, if_pc, prog[2+got], 8 + 4 * got);
        end
        got++;
      end
      next_cycle();
    end
    #1;
    checks++;
    if (got !== 3 || fetch_done !== 1'b1) begin
      failures++; $display("FAIL redir_total got=%0d/%b exp=3/1", got, fetch_done);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (fetch_done !== 1'b0 || address_rom !== 32'h4 || rd_en_rom !== 1'b1) begin
      failures++; $display("FAIL redir_done_clear got=%b %h %b exp=0 00000004 1", fetch_done, address_rom, rd_en_rom);
    end
    next_cycle();
  endtask

  task automatic test_redirect_pop();
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    #1;
    checks++;
    if (if_valid !== 1'b0) begin
      failures++; $display("FAIL rpop_valid got=%b exp=0", if_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (if_valid !== 1'b0) begin
        failures++; $display("FAIL rpop_empty c=%0d got=%b exp=0", c, if_valid);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (if_valid !== 1'b1 || if_instr !== prog[4] || if_pc !== 32'h10) begin
      failures++; $display("FAIL rpop_target got=%b %h@%h exp=1 %h@00000010", if_valid, if_instr, if_pc, prog[4]);
    end
    next_cycle();
    #1;
    checks++;
    if (if_valid !== 1'b0 || fetch_done !== 1'b1) begin
      failures++; $display("FAIL rpop_after got=%b%b exp=01", if_valid, fetch_done);
    end
    next_cycle();
  endtask

  task automatic test_fetch_en();
    int  got;
    bit  found;
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b1;
    repeat (2) next_cycle();
    fetch_en = 1'b0;
    got = 0;
    for (int c = 2; c < 10; c++) begin
      #1;
      checks++;
      if (HSEL1 !== 1'b0 || rd_en_rom !== 1'b0) begin
        failures++; $display("FAIL fen_idle c=%0d got=%b%b exp=00", c, HSEL1, rd_en_rom);
      end
      if (if_valid) begin
        checks++;
        if (got >= 2 || if_instr !== prog[got] || if_pc !== 32'(4 * got)) begin
          failures++; $display("FAIL fen_word n=%0d got=%h@%h exp=%h@%h", got, if_instr, if_pc, prog[got % 5], 4 * got);
        end
        got++;
      end
      next_cycle();
    end
    checks++;
    if (got !== 2) begin
      failures++; $display("FAIL fen_total got=%0d exp=2", got);
    end
    fetch_en = 1'b1;
    #1;
    checks++;
    if (rd_en_rom !== 1'b1 || address_rom !== 32'h8) begin
      failures++; $display("FAIL fen_resume got=%b@%h exp=1@00000008", rd_en_rom, address_rom);
    end
    next_cycle();
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      #1;
      if (if_valid) begin
        found = 1'b1;
        checks++;
        if (if_instr !== prog[2] || if_pc !== 32'h8) begin
          failures++; $display("FAIL fen_next got=%h@%h exp=%h@00000008", if_instr, if_pc, prog[2]);
        end
      end
      next_cycle();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL fen_timeout got=none exp=word@00000008");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_en = 1'b1;
    if_ready = 1'b0;
    repeat (3) next_cycle();
    #1;
    checks++;
    if (if_valid !== 1'b1 || int'(dut.count_q) !== 2) begin
      failures++; $display("FAIL rmid_setup got=%b/%0d exp=1/2", if_valid, dut.count_q);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0 || rd_en_rom !== 1'b0 || address_rom !== RESET_PC || if_pc !== 32'h0) begin
      failures++; $display("FAIL rmid_async got=%b%b %h %h exp=00 %h 0", if_valid, rd_en_rom, address_rom, if_pc, RESET_PC);
    end
    repeat (2) next_cycle();
    reset = 1'b0;
    if_ready = 1'b1;
    #1;
    checks++;
    if (rd_en_rom !== 1'b1 || address_rom !== RESET_PC) begin
      failures++; $display("FAIL rmid_restart got=%b@%h exp=1@%h", rd_en_rom, address_rom, RESET_PC);
    end
    repeat (2) next_cycle();
    #1;
    checks++;
    if (if_valid !== 1'b1 || if_instr !== prog[0] || if_pc !== RESET_PC) begin
      failures++; $display("FAIL rmid_first got=%b %h@%h exp=1 %h@%h", if_valid, if_instr, if_pc, prog[0], RESET_PC);
    end
    next_cycle();
  endtask

  task automatic test_random();
    int delivered;
    do_reset();
    delivered = 0;
    for (int c = 0; c < 800; c++) begin
      fetch_en = ($urandom_range(0, 9) != 0);
      if_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = RESET_PC + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3));
      #1;
      if (if_valid && if_ready) delivered++;
      next_cycle();
    end
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    checks++;
    if (delivered < 50) begin
      failures++; $display("FAIL rand_delivered got=%0d exp>=50", delivered);
    end
    next_cycle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_fetch_en();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
